// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter:
// FSM state encoding, requester IDs and latency-counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // Width of a counter that must hold values up to mem_lat.
    function automatic int lat_cnt_w(input int mem_lat);
        return (mem_lat < 2) ? 1 : $clog2(mem_lat + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_prio.sv
// Fetch/data winner select with a data-streak limit against fetch starvation.
// Ports: clk, rst (async active-low), if_req, d_req, grant_en in;
//        grant_valid, grant_id (REQ_IF/REQ_D) out.
module arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_id
);

    localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          starve;

    always_comb begin
        starve      = (streak_q == SW'(STARVE_LIM));
        grant_valid = if_req | d_req;
        grant_id    = REQ_IF;
        if (d_req && !(if_req && starve)) begin
            grant_id = REQ_D;
        end

        // A data win over a pending fetch implies !starve, so the
        // increment below saturates at STARVE_LIM by construction.
        streak_d = streak_q;
        if (grant_en && grant_valid) begin
            if (grant_id == REQ_IF) begin
                streak_d = '0;
            end else if (if_req) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch
// and load/store; one transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Ports: clk, rst (async active-low); if_* fetch port; d_* data port;
//        mem_* command outputs and mem_rdata input. All outputs registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = lat_cnt_w(MEM_LAT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gid_q, gid_d;
    logic               wr_q, wr_d;
    logic               if_ready_q, if_ready_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic               d_ready_q, d_ready_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [BE_W-1:0]    mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic grant_valid;
    logic grant_id;

    arb_prio #(
        .STARVE_LIM(STARVE_LIM)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .d_req      (d_req),
        .grant_en   (state_q == ST_IDLE),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gid_d       = gid_q;
        wr_d        = wr_q;
        if_ready_d  = 1'b0;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d  = ST_ISSUE;
                    gid_d    = grant_id;
                    mem_en_d = 1'b1;
                    if (grant_id == REQ_D) begin
                        d_ready_d   = 1'b1;
                        wr_d        = d_we;
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        if_ready_d  = 1'b1;
                        wr_d        = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MEM_LAT - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    // rvalid is set here so it is registered high in RESP.
                    state_d = ST_RESP;
                    if (gid_q == REQ_IF) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        if (!wr_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gid_q       <= REQ_IF;
            wr_q        <= 1'b0;
            if_ready_q  <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gid_q       <= gid_d;
            wr_q        <= wr_d;
            if_ready_q  <= if_ready_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 runs MEM_LAT=1,
// instance 1 runs MEM_LAT=3 for the mid-transaction reset case.
`timescale 1ns/1ps
module tb_mem_arbiter;

    typedef enum logic [1:0] {
        EV_IFRDY = 2'd0,
        EV_DRDY  = 2'd1,
        EV_IFRV  = 2'd2,
        EV_DRV   = 2'd3
    } ev_e;

    typedef struct {
        ev_e         kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    logic        rst       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_ready  [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [3:0]  d_be      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_ready   [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [3:0]  mem_be    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    exp_t exp_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0010_0093;
            32'h104: return 32'h0020_0113;
            32'h008: return 32'h1234_5678;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [31:0] pipe [LAT];

        mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_LIM(4)
        ) u_dut (
            .clk(clk), .rst(rst[gi]),
            .if_req(if_req[gi]), .if_addr(if_addr[gi]),
            .if_ready(if_ready[gi]), .if_rvalid(if_rvalid[gi]),
            .if_rdata(if_rdata[gi]),
            .d_req(d_req[gi]), .d_we(d_we[gi]), .d_be(d_be[gi]),
            .d_addr(d_addr[gi]), .d_wdata(d_wdata[gi]),
            .d_ready(d_ready[gi]), .d_rvalid(d_rvalid[gi]),
            .d_rdata(d_rdata[gi]),
            .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_be(mem_be[gi]),
            .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]),
            .mem_rdata(mem_rdata[gi])
        );

        // Read data appears LAT cycles after the command is sampled;
        // any other cycle shows a junk word.
        always @(posedge clk) begin
            pipe[0] <= (mem_en[gi] && !mem_we[gi]) ? mem_val(mem_addr[gi])
                                                   : 32'hBADB_AD00;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[gi] = pipe[LAT-1];
    end

    task automatic chk(input string nm, input logic [159:0] got,
                       input logic [159:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    function automatic logic [159:0] outs(input int i);
        return {22'd0, if_ready[i], if_rvalid[i], if_rdata[i],
                d_ready[i], d_rvalid[i], d_rdata[i],
                mem_en[i], mem_we[i], mem_be[i], mem_addr[i], mem_wdata[i]};
    endfunction

    task automatic push(input int i, input ev_e k, input int c,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic we);
        exp_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.data = d; e.be = be; e.we = we;
        exp_q[i].push_back(e);
    endtask

    task automatic mon(input int i);
        ev_e  k;
        exp_t e;
        logic [159:0] got, want;
        if (!rst[i]) return;
        if ((mem_en[i] || mem_we[i]) && !(if_ready[i] || d_ready[i])) begin
            n_vec++;
            n_fail++;
            $display("FAIL inst%0d mem_cmd_stray cyc=%0d en=%b we=%b want 0",
                     i, cyc, mem_en[i], mem_we[i]);
        end
        if (!(if_ready[i] || d_ready[i] || if_rvalid[i] || d_rvalid[i]))
            return;
        if (if_ready[i])      k = EV_IFRDY;
        else if (d_ready[i])  k = EV_DRDY;
        else if (if_rvalid[i]) k = EV_IFRV;
        else                  k = EV_DRV;
        if (exp_q[i].size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL inst%0d unexpected_event kind=%0d cyc=%0d want none",
                     i, k, cyc);
            return;
        end
        e = exp_q[i].pop_front();
        if (k == EV_IFRDY || k == EV_DRDY) begin
            got  = {57'd0, k, 32'(cyc), mem_addr[i], mem_we[i], mem_be[i],
                    e.we ? mem_wdata[i] : 32'd0};
            want = {57'd0, e.kind, 32'(e.cyc), e.addr, e.we, e.be,
                    e.we ? e.data : 32'd0};
            chk($sformatf("inst%0d grant", i), got, want);
        end else begin
            got  = {94'd0, k, 32'(cyc), (k == EV_IFRV) ? if_rdata[i] : d_rdata[i]};
            want = {94'd0, e.kind, 32'(e.cyc), e.data};
            chk($sformatf("inst%0d resp", i), got, want);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) mon(i);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i, input bit dport);
        int n = 0;
        while (!(dport ? d_ready[i] : if_ready[i]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL inst%0d ready_timeout port=%0d got none want pulse",
                     i, dport);
        end
        tick(1);
    endtask

    int t;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; if_req[i] = 1'b0; if_addr[i] = '0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_be[i] = '0;
            d_addr[i] = '0; d_wdata[i] = '0;
        end

        // Reset with a pending fetch: everything stays 0.
        if_req[0] = 1'b1; if_req[1] = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_outs_i0", outs(0), 160'd0);
        chk("rst_outs_i1", outs(1), 160'd0);
        tick(1);
        if_req[0] = 1'b0; if_req[1] = 1'b0;
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick(10);
        @(negedge clk);
        chk("idle_outs_i0", outs(0), 160'd0);
        tick(1);

        // Single fetch.
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        push(0, EV_IFRDY, t+1, 32'h100, 32'h0, 4'hF, 1'b0);
        push(0, EV_IFRV,  t+3, 32'h0, 32'h0010_0093, 4'h0, 1'b0);
        wait_ready(0, 1'b0);
        if_req[0] = 1'b0;
        tick(4);

        // Simultaneous requests: data first, fetch one transaction later.
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 32'h104;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h8;
        push(0, EV_DRDY,  t+1, 32'h8,   32'h0, 4'hF, 1'b0);
        push(0, EV_DRV,   t+3, 32'h0,   32'h1234_5678, 4'h0, 1'b0);
        push(0, EV_IFRDY, t+5, 32'h104, 32'h0, 4'hF, 1'b0);
        push(0, EV_IFRV,  t+7, 32'h0,   32'h0020_0113, 4'h0, 1'b0);
        wait_ready(0, 1'b1);
        d_req[0] = 1'b0;
        wait_ready(0, 1'b0);
        if_req[0] = 1'b0;
        tick(4);

        // Starvation: both held; D D D D F, then the streak restarts.
        t = cyc;
        if_req[0] = 1'b1; if_addr[0] = 32'h104;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h10;
        for (int g = 0; g < 10; g++) begin
            if (g % 5 == 4) begin
                push(0, EV_IFRDY, t+4*g+1, 32'h104, 32'h0, 4'hF, 1'b0);
                push(0, EV_IFRV,  t+4*g+3, 32'h0, 32'h0020_0113, 4'h0, 1'b0);
            end else begin
                push(0, EV_DRDY, t+4*g+1, 32'h10, 32'h0, 4'hF, 1'b0);
                push(0, EV_DRV,  t+4*g+3, 32'h0, 32'hA5A5_0010, 4'h0, 1'b0);
            end
        end
        tick(38);
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        tick(6);

        // Store: one-cycle write command, d_rdata keeps the last load.
        t = cyc;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'b0011;
        d_addr[0] = 32'h200; d_wdata[0] = 32'hDEAD_BEEF;
        push(0, EV_DRDY, t+1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        push(0, EV_DRV,  t+3, 32'h0, 32'hA5A5_0010, 4'h0, 1'b0);
        wait_ready(0, 1'b1);
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        tick(4);

        // MEM_LAT=3: fetch and load, then reset in WAIT.
        t = cyc;
        if_req[1] = 1'b1; if_addr[1] = 32'h100;
        push(1, EV_IFRDY, t+1, 32'h100, 32'h0, 4'hF, 1'b0);
        push(1, EV_IFRV,  t+5, 32'h0, 32'h0010_0093, 4'h0, 1'b0);
        wait_ready(1, 1'b0);
        if_req[1] = 1'b0;
        tick(5);

        t = cyc;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_be[1] = 4'hF; d_addr[1] = 32'h8;
        push(1, EV_DRDY, t+1, 32'h8, 32'h0, 4'hF, 1'b0);
        push(1, EV_DRV,  t+5, 32'h0, 32'h1234_5678, 4'h0, 1'b0);
        wait_ready(1, 1'b1);
        d_req[1] = 1'b0;
        tick(5);

        t = cyc;
        d_req[1] = 1'b1; d_addr[1] = 32'h10;
        push(1, EV_DRDY, t+1, 32'h10, 32'h0, 4'hF, 1'b0);
        wait_ready(1, 1'b1);
        d_req[1] = 1'b0;
        tick(1);
        rst[1] = 1'b0;
        #1;
        chk("rst_mid_wait_i1", outs(1), 160'd0);
        tick(2);
        rst[1] = 1'b1;
        tick(12);

        t = cyc;
        if_req[1] = 1'b1; if_addr[1] = 32'h104;
        push(1, EV_IFRDY, t+1, 32'h104, 32'h0, 4'hF, 1'b0);
        push(1, EV_IFRV,  t+5, 32'h0, 32'h0020_0113, 4'h0, 1'b0);
        wait_ready(1, 1'b0);
        if_req[1] = 1'b0;
        tick(6);

        chk("pending_i0", 160'(exp_q[0].size()), 160'd0);
        chk("pending_i1", 160'(exp_q[1].size()), 160'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port and the load/store port.
- Sits between the cpu core and the unified memory.
- Runs one transaction at a time through a fixed sequence: issue, wait for the memory latency, respond.
- Data requests have priority; a streak limit prevents fetch starvation.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)
MEM_LAT, 1, cycles from the memory sampling a command to mem_rdata being valid (>=1)
STARVE_LIM, 4, consecutive data grants allowed while if_req is pending before fetch is forced

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse: fetch accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched word
d_req  in  1  data request; held with all d_* inputs until d_ready
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_W/8  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ready  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
d_rdata  out  DATA_W  load data
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- All outputs are registered.
- rst low clears every output to 0, clears the state to IDLE and clears the streak counter. This takes effect immediately, including mid-transaction.
- After reset during a transaction: the transaction is dropped, no rvalid is ever issued for it, and requesters re-request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise, at the edge, register the grant. Go to ISSUE, load mem_* from the winner, and pulse the winner's ready.
- ISSUE (1 cycle): mem_en=1; mem_we/be/addr/wdata hold the command (mem_we=0, mem_be=all ones for a fetch). Then go to WAIT, load the latency counter with MEM_LAT-1, and drop mem_en.
- WAIT (MEM_LAT cycles):
  - Counter decrements each cycle.
  - At the edge where it reads 0, capture mem_rdata into the winner's rdata (loads and fetches only) and go to RESP.
- RESP (1 cycle): winner's rvalid=1, then go to IDLE.
- Timing with a request first sampled in IDLE at cycle t:
  - ready and mem_en are high in t+1.
  - rvalid is high in t+2+MEM_LAT.
  - A new grant happens no earlier than sampling at t+3+MEM_LAT.
- Stores: d_rvalid pulses as completion; d_rdata keeps its previous value.
- rdata registers hold their value until the next capture.
- Arbitration, applied only in IDLE:
  - Only one requesting: that one wins.
  - Both requesting: data wins, unless streak==STARVE_LIM, in which case fetch wins.
- Streak counter:
  - Increments on a data grant made while if_req=1, saturating at STARVE_LIM.
  - Clears on any fetch grant.
  - Unchanged on a data grant with if_req=0.
- Requesters that drop req before ready: the request is simply not granted. The block does not check protocol violations.
- Address and data widths pass through unchanged; no alignment checks.

Decomposition:
- Package mem_arb_pkg:
  - state encodings ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP;
  - requester IDs REQ_IF=0, REQ_D=1;
  - latency counter width as $clog2(MEM_LAT+1).
- Sub-module arb_prio: combinational winner select plus the registered streak counter. Inputs if_req, d_req, grant_en; outputs grant_valid, grant_id. Parameter STARVE_LIM.
- The FSM, command registers and response registers stay in mem_arbiter.

Test Plan:
1. Reset and idle: rst=0 with if_req=1 -> every output is 0; release rst with no requests for 10 cycles -> mem_en stays 0.
2. Single fetch, MEM_LAT=1: if_req, if_addr=0x100 at t; memory returns 0x00100093 -> if_ready, mem_en=1, mem_addr=0x100, mem_we=0 at t+1; if_rvalid=1 with if_rdata=0x00100093 at t+3.
3. Simultaneous requests: if_req (0x104) and d_req load (0x8) at t -> d_ready at t+1; if_ready one transaction later, at t+5; responses come back in the same order.
4. Starvation, STARVE_LIM=4: d_req held high continuously, if_req held high -> four d_ready pulses, then if_ready on the fifth grant; the streak then restarts.
5. Store: d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF for exactly one cycle; d_rvalid pulses; d_rdata unchanged.
6. Reset mid-operation, MEM_LAT=3: assert rst during WAIT -> outputs are 0 within the same cycle; after release, no stray if_rvalid/d_rvalid; the next request completes normally.
